// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency instruction memory,
// and buffers {instruction, pc} pairs in a small FIFO toward decode.
module fetch_unit #(
    parameter int unsigned           ADDR_W   = 5,
    parameter int unsigned           INST_W   = 13,
    parameter int unsigned           DEPTH    = 2,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] issued_pc;
    logic              inflight;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic run;
    logic pop;
    logic push;
    logic redir;
    logic credit;
    logic issue;

    assign run      = (state == S_RUN);
    assign ir_valid = (count != '0);
    assign ir_out   = inst_mem[rd_ptr];
    assign ir_pc    = pc_mem[rd_ptr];
    assign pop      = ir_valid & ir_ready;
    assign redir    = run & redirect_valid;
    assign push     = inflight & ~redir;

    // A slot is reserved for every in-flight read so a return can never overflow.
    assign credit = (SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop)) < SUM_W'(DEPTH);
    assign issue  = run & fetch_en & ~redirect_valid & credit;

    assign imem_rd_en = issue;
    assign imem_addr  = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_WAIT;
            pc        <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            state <= S_RUN;
            if (redir) begin
                // Flush buffered and in-flight work; restart at the target.
                pc       <= redirect_pc;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc        <= pc + ADDR_W'(1);
                    issued_pc <= pc;
                end
                if (push) begin
                    inst_mem[wr_ptr] <= imem_rdata;
                    pc_mem[wr_ptr]   <= issued_pc;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule
